// File: rtl/fired_tag_fifo.sv
// Fired-neuron tag queue between the neuron update stage and the synaptic unit.
// A per-timestep fired bitmap drops duplicate tags before they reach the queue.
module fired_tag_fifo #(
  parameter int numneurons = 2,
  parameter int tagbits    = 1,
  parameter int ptrbits    = 1
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic               enq_req,
  input  logic [tagbits-1:0] enq_tag,
  input  logic               req_deq,
  input  logic               step_clear,
  input  logic               flush,
  output logic [tagbits-1:0] src_tag_out,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [ptrbits:0]   count,
  output logic               dup_drop,
  output logic               overflow,
  output logic               underflow
);
  localparam int               DEPTH   = 1 << ptrbits;
  localparam logic [ptrbits:0] DEPTH_C = {1'b1, {ptrbits{1'b0}}};
  localparam logic [tagbits:0] NUM_C   = (tagbits+1)'(numneurons);

  logic [tagbits-1:0]    mem_q [DEPTH];
  logic [ptrbits-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ptrbits:0]      count_q, count_d;
  logic [numneurons-1:0] fired_q, fired_d;
  logic                  dup_q, dup_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                  in_range, seen, acc, deq;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_C);
  assign count       = count_q;
  assign src_tag_out = fifo_empty ? '0 : mem_q[rptr_q];
  assign dup_drop    = dup_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  // A same-cycle step_clear makes the bitmap look empty to this cycle's enqueue.
  always_comb begin
    in_range = ({1'b0, enq_tag} < NUM_C);
    seen     = 1'b0;
    for (int i = 0; i < numneurons; i++)
      if (enq_tag == tagbits'(i) && fired_q[i] && !step_clear) seen = 1'b1;
    deq = req_deq && !fifo_empty && !flush;
    acc = enq_req && in_range && !seen && (!fifo_full || req_deq) && !flush;
  end

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    fired_d = step_clear ? '0 : fired_q;
    dup_d   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      fired_d = '0;
    end else begin
      if (deq) rptr_d = rptr_q + ptrbits'(1);
      if (acc) begin
        wptr_d = wptr_q + ptrbits'(1);
        for (int i = 0; i < numneurons; i++)
          if (enq_tag == tagbits'(i)) fired_d[i] = 1'b1;
      end
      case ({acc, deq})
        2'b10:   count_d = count_q + (ptrbits+1)'(1);
        2'b01:   count_d = count_q - (ptrbits+1)'(1);
        default: count_d = count_q;
      endcase
      dup_d = enq_req && (!in_range || seen);
      if (enq_req && in_range && !seen && fifo_full && !req_deq) ovf_d = 1'b1;
      if (req_deq && fifo_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      fired_q <= '0;
      dup_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      fired_q <= fired_d;
      dup_q   <= dup_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (acc) mem_q[wptr_q] <= enq_tag;
  end
endmodule

// File: tb/tb_fired_tag_fifo.sv
// Self-checking bench for fired_tag_fifo: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fired_tag_fifo;
  localparam int NN = 4, TB = 2, PB = 2, DEPTH = 4;

  logic          clk = 1'b0;
  logic          asyn_reset;
  logic          enq_req, req_deq, step_clear, flush;
  logic [TB-1:0] enq_tag;
  logic [TB-1:0] src_tag_out;
  logic          fifo_empty, fifo_full, dup_drop, overflow, underflow;
  logic [PB:0]   count;

  int checks = 0;
  int errors = 0;

  // reference model
  int q[$];
  bit fired[NN];
  bit m_dup, m_ovf, m_unf;

  fired_tag_fifo #(.numneurons(NN), .tagbits(TB), .ptrbits(PB)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .enq_req(enq_req), .enq_tag(enq_tag),
    .req_deq(req_deq), .step_clear(step_clear), .flush(flush),
    .src_tag_out(src_tag_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .count(count), .dup_drop(dup_drop), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    foreach (fired[i]) fired[i] = 1'b0;
    m_dup = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input bit e, input int t, input bit d, input bit sc, input bit fl);
    bit full, empty, acc;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    acc   = 0;
    m_dup = 0;
    if (fl) begin
      q.delete();
      foreach (fired[i]) fired[i] = 1'b0;
    end else begin
      if (sc) foreach (fired[i]) fired[i] = 1'b0;
      if (d && empty) m_unf = 1;
      if (e) begin
        if (t >= NN || fired[t]) m_dup = 1;
        else if (full && !d) m_ovf = 1;
        else acc = 1;
      end
      if (d && !empty) void'(q.pop_front());
      if (acc) begin
        q.push_back(t);
        fired[t] = 1'b1;
      end
    end
  endtask

  // one clock: inputs held across the edge, model advanced at the edge
  task automatic cyc(input bit e, input int t, input bit d, input bit sc, input bit fl);
    enq_req = e; enq_tag = TB'(t); req_deq = d; step_clear = sc; flush = fl;
    @(posedge clk);
    model_step(e, t, d, sc, fl);
    #1;
    enq_req = 0; enq_tag = '0; req_deq = 0; step_clear = 0; flush = 0;
  endtask

  task automatic test_reset();
    asyn_reset = 1'b1;
    enq_req = 0; enq_tag = '0; req_deq = 0; step_clear = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 asyn_reset = 1'b0;
    #1;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (src_tag_out !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", src_tag_out); end
    checks++; if ({dup_drop, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {dup_drop, overflow, underflow}); end
  endtask

  task automatic test_basic();
    int exp_cnt[3] = '{1, 2, 3};
    int tags[3]    = '{2, 0, 3};
    for (int i = 0; i < 3; i++) begin
      cyc(1, tags[i], 0, 0, 0);
      checks++; if (count !== 3'(exp_cnt[i])) begin errors++; $display("FAIL basic_count%0d got %0d want %0d", i, count, exp_cnt[i]); end
      checks++; if (src_tag_out !== 2'd2) begin errors++; $display("FAIL basic_head%0d got %0d want 2", i, src_tag_out); end
    end
    cyc(0, 0, 1, 0, 0);
    checks++; if (src_tag_out !== 2'd0) begin errors++; $display("FAIL basic_deq1 got %0d want 0", src_tag_out); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (src_tag_out !== 2'd3) begin errors++; $display("FAIL basic_deq2 got %0d want 3", src_tag_out); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_dup();
    cyc(1, 1, 0, 0, 0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL dup_first got %0d want 1", count); end
    cyc(1, 1, 0, 0, 0);
    checks++; if (dup_drop !== 1'b1) begin errors++; $display("FAIL dup_pulse got %b want 1", dup_drop); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL dup_count got %0d want 1", count); end
    cyc(0, 0, 0, 1, 0);
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL dup_pulse_end got %b want 0", dup_drop); end
    cyc(1, 1, 0, 0, 0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL dup_after_clear got %0d want 2", count); end
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL dup_after_clear_drop got %b want 0", dup_drop); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL dup_drain got %b want 1", fifo_empty); end
  endtask

  task automatic test_overflow();
    cyc(0, 0, 0, 1, 0);
    for (int t = 0; t < 4; t++) cyc(1, t, 0, 0, 0);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", fifo_full); end
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
    cyc(1, 2, 1, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_swap_count got %0d want 4", count); end
    checks++; if (src_tag_out !== 2'd1) begin errors++; $display("FAIL ovf_swap_head got %0d want 1", src_tag_out); end
    // tag 1 must still be enqueueable: the overflowed attempt left its bit clear
    cyc(1, 1, 1, 0, 0);
    checks++; if (dup_drop !== 1'b0 || count !== 3'd4 || src_tag_out !== 2'd2) begin
      errors++; $display("FAIL ovf_bit_clear got dup=%b cnt=%0d head=%0d want dup=0 cnt=4 head=2", dup_drop, count, src_tag_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (src_tag_out !== TB'(q[0])) begin errors++; $display("FAIL ovf_order%0d got %0d want %0d", i, src_tag_out, q[0]); end
      cyc(0, 0, 1, 0, 0);
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ovf_drain got %b want 1", fifo_empty); end
  endtask

  task automatic test_underflow();
    cyc(0, 0, 1, 1, 0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b want 1", underflow); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL unf_count got %0d want 0", count); end
    cyc(1, 3, 1, 0, 0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL unf_nobypass_count got %0d want 1", count); end
    checks++; if (src_tag_out !== 2'd3) begin errors++; $display("FAIL unf_nobypass_head got %0d want 3", src_tag_out); end
  endtask

  task automatic test_flush();
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", count); end
    cyc(1, 2, 0, 0, 1);
    checks++; if (count !== 3'd0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got cnt=%0d empty=%b want 0/1", count, fifo_empty); end
    checks++; if (overflow !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL flush_sticky got %b%b want 11", overflow, underflow); end
    cyc(1, 2, 0, 0, 0);
    checks++; if (count !== 3'd1 || src_tag_out !== 2'd2) begin errors++; $display("FAIL flush_enq2 got cnt=%0d head=%0d want 1/2", count, src_tag_out); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (count !== 3'd2 || dup_drop !== 1'b0) begin errors++; $display("FAIL flush_bitmap got cnt=%0d dup=%b want 2/0", count, dup_drop); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_wrap();
    for (int s = 0; s < 10; s++) begin
      int a, b;
      a = $urandom_range(0, 3);
      b = (a + $urandom_range(1, 3)) % 4;
      cyc(1, a, 0, 1, 0);
      cyc(1, b, 0, 0, 0);
      checks++; if (src_tag_out !== TB'(a)) begin errors++; $display("FAIL wrap%0d_a got %0d want %0d", s, src_tag_out, a); end
      cyc(0, 0, 1, 0, 0);
      checks++; if (src_tag_out !== TB'(b)) begin errors++; $display("FAIL wrap%0d_b got %0d want %0d", s, src_tag_out, b); end
      cyc(0, 0, 1, 0, 0);
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0, $urandom_range(0, 3), ($urandom % 3) == 0,
          ($urandom % 6) == 0, ($urandom % 50) == 0);
      checks++;
      if (count !== 3'(q.size()) || fifo_empty !== (q.size() == 0) || fifo_full !== (q.size() == DEPTH) ||
          src_tag_out !== (q.size() == 0 ? 2'd0 : TB'(q[0])) || dup_drop !== m_dup ||
          overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("FAIL rand%0d got cnt=%0d e=%b f=%b h=%0d d=%b o=%b u=%b want cnt=%0d h=%0d d=%b o=%b u=%b",
                 n, count, fifo_empty, fifo_full, src_tag_out, dup_drop, overflow, underflow,
                 q.size(), (q.size() == 0) ? 0 : q[0], m_dup, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    checks++; if (count !== 3'd2 || overflow !== 1'b1 || underflow !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got cnt=%0d o=%b u=%b want 2/1/1", count, overflow, underflow);
    end
    #2 asyn_reset = 1'b1;
    #1;
    checks++; if (fifo_empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL rstmid_empty got e=%b cnt=%0d want 1/0", fifo_empty, count); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rstmid_sticky got %b%b want 00", overflow, underflow); end
    @(posedge clk);
    #1 asyn_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_overflow();
    test_underflow();
    test_flush();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fired_tag_fifo.md
# fired_tag_fifo

Queue of fired-neuron tags between the neuron update stage and the synaptic processing unit. The neuron update stage enqueues the tag of each neuron that spikes in the current timestep. The synaptic processing unit dequeues one tag at a time and sweeps its efferent weights. A per-neuron fired bitmap drops duplicate enqueues, so each neuron is queued at most once per timestep. The block also provides occupancy reporting and sticky overflow and underflow error flags.

## Interface
- numneurons, 2: number of neurons; valid tags are 0..numneurons-1
- tagbits, 1: tag width; 2**tagbits >= numneurons
- ptrbits, 1: queue depth is 2**ptrbits entries; 2**ptrbits >= numneurons

- clk  in  1  clock, rising edge
- asyn_reset  in  1  reset, asynchronous, active-high
- enq_req  in  1  enqueue request from the neuron update stage; one tag per cycle
- enq_tag  in  tagbits  tag to enqueue
- req_deq  in  1  dequeue request from the synaptic processing unit
- step_clear  in  1  pulse: a new timestep begins; clears the fired bitmap only
- flush  in  1  pulse: empties the queue and clears the bitmap
- src_tag_out  out  tagbits  head-of-queue tag; 0 when empty
- fifo_empty  out  1  queue holds no entries
- fifo_full  out  1  queue holds 2**ptrbits entries
- count  out  ptrbits+1  current occupancy
- dup_drop  out  1  one-cycle pulse: an enqueue was dropped as a duplicate or out-of-range tag
- overflow  out  1  sticky: an enqueue was attempted while full and without a same-cycle dequeue
- underflow  out  1  sticky: a dequeue was attempted while empty

## Operation
- Storage:
  - Circular buffer of 2**ptrbits tags.
  - Read pointer and write pointer, each ptrbits wide, wrap naturally modulo depth.
  - Occupancy register count.
  - Fired bitmap of numneurons bits.
- Reset, asynchronous: pointers 0, count 0, bitmap all 0, overflow 0, underflow 0, dup_drop 0. Outputs after reset: fifo_empty 1, fifo_full 0, src_tag_out 0. Reset mid-operation discards all queued tags immediately.
- Enqueue is accepted when all of the following hold:
  - enq_req is 1;
  - enq_tag < numneurons;
  - the bitmap bit for enq_tag is 0, where the bitmap is taken as already cleared if step_clear is 1 this cycle;
  - the queue is not full, or req_deq is 1 this cycle.
- On an accepted enqueue: the tag is written at the write pointer, the write pointer increments, and the bitmap bit for enq_tag is set.
- Enqueue rejection:
  - enq_req with an out-of-range tag or an already-set bitmap bit: dup_drop is 1 the next cycle, no state change.
  - enq_req while full with no dequeue: overflow is set, the tag is dropped, and the bitmap bit is not set.
- Dequeue: req_deq while not empty advances the read pointer.
  - req_deq while empty: ignored, underflow is set.
  - A same-cycle enqueue into an empty queue is not bypassed to the dequeue.
- Count updates: +1 for accepted enqueue only, -1 for effective dequeue only, unchanged when both or neither occur.
- step_clear: all bitmap bits are cleared. Queue contents are untouched, so tags from the previous step still drain.
- flush: pointers and count return to 0 and the bitmap is cleared. flush has priority over same-cycle enq_req, req_deq and step_clear, which are all ignored that cycle. Sticky flags are not cleared by flush; only asyn_reset clears them.

## Timing
- All state is updated on the rising edge of clk.
- fifo_empty, fifo_full and count are decoded from registered state and reflect the previous edge.
- src_tag_out is a combinational read of the head entry, valid while fifo_empty is 0. The consumer samples src_tag_out in the same cycle it decides to dequeue. req_deq may arrive one cycle later as a registered pulse; the head does not change until the edge at which req_deq is high.
- Latency:
  - Enqueue into an empty queue: fifo_empty falls and src_tag_out is valid the cycle after enq_req.
  - Dequeue: the next head appears the cycle after req_deq.
- The consumer holds req_deq high for exactly one cycle per tag. Each cycle req_deq is high dequeues one entry.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Test plan
- numneurons=4, tagbits=2, ptrbits=2. Reset, then enqueue tags 2, 0, 3 on consecutive cycles.
  - Expect count 1, 2, 3 and src_tag_out 2.
  - Dequeue three times: src_tag_out 0, then 3, then fifo_empty=1.
- Enqueue tag 1 twice in the same timestep.
  - Expect the second enqueue dropped: dup_drop pulses for 1 cycle, count stays 1.
  - Then step_clear, enqueue 1 again: accepted, count 2.
- Fill with 0, 1, 2, 3: fifo_full=1.
  - After step_clear, enqueue tag 1 with no dequeue: overflow=1, count stays 4.
  - Enqueue tag 2 with a same-cycle req_deq: accepted, count stays 4, head becomes 1.
- Empty queue, req_deq pulse: underflow=1, count 0.
  - Same-cycle enqueue of tag 3 with req_deq: count becomes 1, src_tag_out 3.
- Three entries queued and a flush pulse with a same-cycle enq_req of tag 2.
  - Expect count 0, fifo_empty=1 and the bitmap cleared, with overflow and underflow unchanged.
  - A subsequent enqueue of tag 2 is accepted.
- Wrap-around: run 10 enqueue/dequeue pairs with step_clear between steps.
  - Expect FIFO order preserved across pointer wrap.
- Reset mid-operation: assert asyn_reset while count=2, between clock edges.
  - Expect fifo_empty=1 and both sticky flags 0 immediately, before the next edge.
